boreal_wbram_arbiter: RTL

//  Sequences and arbitrates the single-port synaptic weight BRAM (W matrix) between two

---
 rtl/boreal_wbram_arbiter.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/boreal_wbram_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : boreal_wbram_arbiter
// Purpose  : Single-port weight BRAM sequencer. Inference reads take priority
//            over Hebbian write-back, a starvation counter bounds the wait of a
//            pending write, and the bite switch freezes all plasticity writes.
// Revision : 1.0  initial release
// ============================================================================
module boreal_wbram_arbiter #(
  parameter int ADDR_W     = 10,
  parameter int DATA_W     = 16,
  parameter int RD_LAT     = 1,
  parameter int STARVE_MAX = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              bite_switch_n,
  input  logic              inf_req,
  input  logic [ADDR_W-1:0] inf_addr,
  output logic              inf_gnt,
  output logic              inf_rvalid,
  output logic [DATA_W-1:0] inf_rdata,
  input  logic              heb_req,
  input  logic [ADDR_W-1:0] heb_addr,
  input  logic [DATA_W-1:0] heb_wdata,
  output logic              heb_gnt,
  output logic              heb_blocked,
  output logic [ADDR_W-1:0] bram_addr,
  output logic              bram_we,
  output logic [DATA_W-1:0] bram_wdata,
  input  logic [DATA_W-1:0] bram_rdata
);

  localparam int SC_W  = $clog2(STARVE_MAX + 1);
  localparam int LAT_W = 3;
  localparam logic [SC_W-1:0]  c_starve_max = SC_W'(STARVE_MAX);
  localparam logic [LAT_W-1:0] c_rd_lat     = LAT_W'(RD_LAT);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_WAIT = 2'd1,
    WR      = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [SC_W-1:0]     starve_cnt_q, starve_cnt_d;
  logic [LAT_W-1:0]    lat_cnt_q, lat_cnt_d;
  logic                inf_gnt_q, inf_gnt_d;
  logic                inf_rvalid_q, inf_rvalid_d;
  logic [DATA_W-1:0]   inf_rdata_q, inf_rdata_d;
  logic                heb_gnt_q, heb_gnt_d;
  logic                heb_blocked_q, heb_blocked_d;
  logic [ADDR_W-1:0]   bram_addr_q, bram_addr_d;
  logic                bram_we_q, bram_we_d;
  logic [DATA_W-1:0]   bram_wdata_q, bram_wdata_d;
  logic                w_heb_live;

  assign w_heb_live = heb_req & bite_switch_n;

  always_comb begin
    state_d       = state_q;
    starve_cnt_d  = starve_cnt_q;
    lat_cnt_d     = lat_cnt_q;
    inf_gnt_d     = 1'b0;
    inf_rvalid_d  = 1'b0;
    heb_gnt_d     = 1'b0;
    bram_we_d     = 1'b0;
    inf_rdata_d   = inf_rdata_q;
    bram_addr_d   = bram_addr_q;
    bram_wdata_d  = bram_wdata_q;
    heb_blocked_d = ~bite_switch_n;

    case (state_q)
      IDLE: begin
        if (!heb_req) begin
          starve_cnt_d = '0;
        end
        // A pending write wins outright when no read competes, or once it
        // has lost STARVE_MAX arbitrations in a row.
        if (w_heb_live && (!inf_req || (starve_cnt_q == c_starve_max))) begin
          state_d      = WR;
          heb_gnt_d    = 1'b1;
          bram_we_d    = 1'b1;
          bram_addr_d  = heb_addr;
          bram_wdata_d = heb_wdata;
        end else if (inf_req) begin
          state_d     = RD_WAIT;
          inf_gnt_d   = 1'b1;
          bram_addr_d = inf_addr;
          lat_cnt_d   = '0;
          if (w_heb_live && (starve_cnt_q != c_starve_max)) begin
            starve_cnt_d = starve_cnt_q + 1'b1;
          end
        end
      end
      RD_WAIT: begin
        if (lat_cnt_q == c_rd_lat) begin
          inf_rdata_d  = bram_rdata;
          inf_rvalid_d = 1'b1;
          state_d      = IDLE;
        end else begin
          lat_cnt_d = lat_cnt_q + 1'b1;
        end
      end
      WR: begin
        starve_cnt_d = '0;
        state_d      = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (!bite_switch_n) begin
      starve_cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      starve_cnt_q  <= '0;
      lat_cnt_q     <= '0;
      inf_gnt_q     <= 1'b0;
      inf_rvalid_q  <= 1'b0;
      inf_rdata_q   <= '0;
      heb_gnt_q     <= 1'b0;
      heb_blocked_q <= 1'b0;
      bram_addr_q   <= '0;
      bram_we_q     <= 1'b0;
      bram_wdata_q  <= '0;
    end else begin
      state_q       <= state_d;
      starve_cnt_q  <= starve_cnt_d;
      lat_cnt_q     <= lat_cnt_d;
      inf_gnt_q     <= inf_gnt_d;
      inf_rvalid_q  <= inf_rvalid_d;
      inf_rdata_q   <= inf_rdata_d;
      heb_gnt_q     <= heb_gnt_d;
      heb_blocked_q <= heb_blocked_d;
      bram_addr_q   <= bram_addr_d;
      bram_we_q     <= bram_we_d;
      bram_wdata_q  <= bram_wdata_d;
    end
  end

  assign inf_gnt     = inf_gnt_q;
  assign inf_rvalid  = inf_rvalid_q;
  assign inf_rdata   = inf_rdata_q;
  assign heb_gnt     = heb_gnt_q;
  assign heb_blocked = heb_blocked_q;
  assign bram_addr   = bram_addr_q;
  assign bram_we     = bram_we_q;
  assign bram_wdata  = bram_wdata_q;

endmodule
`default_nettype wire
